// File: rtl/riscv_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_run_ctrl
//  Description : Execution controller for the single-cycle RISC-V core.
//                Produces the core clock enable so the board can single-step
//                from a debounced push button, free-run from a switch, or
//                stop at a PC breakpoint. Also counts executed instructions.
//
//  Parameters  : DEBOUNCE_CYCLES - consecutive differing cycles before the
//                                  debounced button flips (>= 2)
//                CNT_W           - instruction counter width
//
//  Ports       : rclk        in   core clock
//                rst         in   asynchronous active-high reset
//                step_btn    in   raw push button (asynchronous)
//                run_sw      in   raw run switch (asynchronous, level)
//                pc          in   current core PC
//                bp_addr     in   breakpoint address
//                bp_valid    in   breakpoint armed
//                cpu_en      out  core clock enable (one commit per high cycle)
//                halted      out  high in HALT or BREAK
//                bp_hit      out  sticky: core stopped at the breakpoint
//                state       out  HALT=00 STEP=01 RUN=10 BREAK=11
//                instr_count out  number of cycles with cpu_en high (wraps)
//
//  Build macro : RUN_CTRL_BP_EN - when defined, the breakpoint comparator is
//                present; otherwise pc/bp_addr/bp_valid are ignored and the
//                BREAK state is unreachable.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             rclk,
    input  logic             rst,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    output logic             cpu_en,
    output logic             halted,
    output logic             bp_hit,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam int                c_DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_STEP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    logic              r_step_meta, r_step_s;
    logic              r_run_meta,  r_run_s;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_step_db, r_step_db_d;
    logic              r_step_req;
    state_t            r_state, w_state_next;
    logic              r_bp_hit, w_bp_hit_next;
    logic [CNT_W-1:0]  r_instr_count;
    logic              w_bp_match;

    // ------------------------------------------------------------------------
    // Breakpoint comparator
    // ------------------------------------------------------------------------
`ifdef RUN_CTRL_BP_EN
    assign w_bp_match = bp_valid & (pc == bp_addr);
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{pc, bp_addr, bp_valid};
    assign w_bp_match  = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Synchronizers, debounce and step pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_step_meta <= 1'b0;
            r_step_s    <= 1'b0;
            r_run_meta  <= 1'b0;
            r_run_s     <= 1'b0;
            r_db_cnt    <= '0;
            r_step_db   <= 1'b0;
            r_step_db_d <= 1'b0;
            r_step_req  <= 1'b0;
        end else begin
            r_step_meta <= step_btn;
            r_step_s    <= r_step_meta;
            r_run_meta  <= run_sw;
            r_run_s     <= r_run_meta;

            if (r_step_s == r_step_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                // This edge is the last of the required run of differing samples
                r_step_db <= ~r_step_db;
                r_db_cnt  <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_W'(1);
            end

            // Rising edge of the debounced button only; release is ignored
            r_step_db_d <= r_step_db;
            r_step_req  <= r_step_db & ~r_step_db_d;
        end
    end

    // ------------------------------------------------------------------------
    // Run-control FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_HALT;
            r_bp_hit      <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state  <= w_state_next;
            r_bp_hit <= w_bp_hit_next;
            if (cpu_en) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Run-control FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_bp_hit_next = r_bp_hit;
        case (r_state)
            ST_HALT: begin
                // The run switch wins over a coincident step request
                if (r_run_s) begin
                    w_state_next  = ST_RUN;
                    w_bp_hit_next = 1'b0;
                end else if (r_step_req) begin
                    w_state_next  = ST_STEP;
                    w_bp_hit_next = 1'b0;
                end
            end
            ST_STEP: begin
                w_state_next = ST_HALT;
            end
            ST_RUN: begin
                if (!r_run_s) begin
                    w_state_next = ST_HALT;
                end else if (w_bp_match) begin
                    w_state_next  = ST_BREAK;
                    w_bp_hit_next = 1'b1;
                end
            end
            ST_BREAK: begin
                // Switching off wins over a coincident step request
                if (!r_run_s) begin
                    w_state_next = ST_HALT;
                end else if (r_step_req) begin
                    w_state_next  = ST_STEP;
                    w_bp_hit_next = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_HALT;
            end
        endcase
    end

    // The breakpoint instruction is blocked in the very cycle the PC reaches it,
    // so it is not committed on the way into BREAK.
    always_comb begin
        cpu_en = 1'b0;
        halted = 1'b0;
        cpu_en = (r_state == ST_STEP) | ((r_state == ST_RUN) & ~w_bp_match);
        halted = (r_state == ST_HALT) | (r_state == ST_BREAK);
    end

    assign bp_hit      = r_bp_hit;
    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_riscv_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_run_ctrl
//  Description : Scoreboard bench for riscv_run_ctrl (DEBOUNCE_CYCLES=4,
//                CNT_W=16). Stimulus pushes the expected cycle, PC and state
//                of every cpu_en pulse; a monitor pops one entry per pulse.
//                Breakpoint scenarios depend on RUN_CTRL_BP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_run_ctrl;

    localparam int c_D = 4;

    logic        rclk = 1'b0;
    logic        rst  = 1'b1;
    logic        step_btn = 1'b0;
    logic        run_sw   = 1'b0;
    logic [31:0] pc;
    logic [31:0] bp_addr  = 32'h0;
    logic        bp_valid = 1'b0;
    logic        cpu_en, halted, bp_hit;
    logic [1:0]  state;
    logic [15:0] instr_count;

    riscv_run_ctrl #(.DEBOUNCE_CYCLES(c_D), .CNT_W(16)) dut (
        .rclk        (rclk),
        .rst         (rst),
        .step_btn    (step_btn),
        .run_sw      (run_sw),
        .pc          (pc),
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .cpu_en      (cpu_en),
        .halted      (halted),
        .bp_hit      (bp_hit),
        .state       (state),
        .instr_count (instr_count)
    );

    always #5 rclk = ~rclk;

    // Cycle index: after posedge n the value is n.
    int cyc = 0;
    always @(posedge rclk) cyc <= cyc + 1;

    // Minimal core model: PC advances by 4 on every committed instruction.
    always @(posedge rclk or posedge rst) begin
        if (rst)         pc <= 32'h0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    typedef struct {
        int          ecyc;
        logic [31:0] epc;
        logic [1:0]  est;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [31:0] p, input logic [1:0] s);
        exp_t e;
        e.ecyc = c; e.epc = p; e.est = s;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge rclk);
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rst = 1'b1; step_btn = 1'b0; run_sw = 1'b0; bp_valid = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    // Monitor: every cpu_en pulse must match the head of the scoreboard.
    always @(negedge rclk) begin
        if (!rst && cpu_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_cpu_en: got pulse at cycle %0d pc %0h expected none", cyc, pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", 64'(cyc), 64'(e.ecyc));
                chk("pulse_pc",    64'(pc),  64'(e.epc));
                chk("pulse_state", 64'(state), 64'(e.est));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, k;
        tick(3);
        rst = 1'b0;
        chk("rst_state", 64'(state), 64'h0);
        chk("rst_halted", 64'(halted), 64'h1);

        // ---- Reset asserted mid-run between edges ----
        c = cyc; run_sw = 1'b1; k = c + 1;
        push(k + 2, 32'h0, 2'b10); push(k + 3, 32'h4, 2'b10); push(k + 4, 32'h8, 2'b10);
        tick(5);
        chk("run_before_rst", 64'(cpu_en), 64'h1);
        #2 rst = 1'b1; run_sw = 1'b0;
        #1;
        chk("rst_cpu_en", 64'(cpu_en), 64'h0);
        chk("rst_halted_mid", 64'(halted), 64'h1);
        chk("rst_state_mid", 64'(state), 64'h0);
        chk("rst_count", 64'(instr_count), 64'h0);
        tick(2);
        rst = 1'b0;

        // ---- Single step, held 20 cycles ----
        c = cyc; step_btn = 1'b1;
        push(c + 4 + c_D, 32'h0, 2'b01);
        tick(4 + c_D);
        chk("step_state", 64'(state), 64'h1);
        tick(1);
        chk("step_back_halt", 64'(state), 64'h0);
        tick(11);
        step_btn = 1'b0;
        tick(8);
        chk("step_count", 64'(instr_count), 64'h1);
        chk("step_pc", 64'(pc), 64'h4);

        // ---- 3-cycle bounce then a real press ----
        step_btn = 1'b1; tick(3);
        step_btn = 1'b0; tick(3);
        c = cyc; step_btn = 1'b1;
        push(c + 4 + c_D, 32'h4, 2'b01);
        tick(15);
        step_btn = 1'b0;
        tick(8);
        chk("bounce_count", 64'(instr_count), 64'h2);

`ifdef RUN_CTRL_BP_EN
        // ---- Run to breakpoint at 0xC, then step past it and resume ----
        do_reset();
        bp_addr = 32'hC; bp_valid = 1'b1;
        c = cyc; run_sw = 1'b1; k = c + 1;
        push(k + 2, 32'h0, 2'b10); push(k + 3, 32'h4, 2'b10); push(k + 4, 32'h8, 2'b10);
        tick(6);
        chk("bp_cpu_en_low", 64'(cpu_en), 64'h0);
        chk("bp_pc", 64'(pc), 64'hC);
        chk("bp_state_run", 64'(state), 64'h2);
        tick(1);
        chk("break_state", 64'(state), 64'h3);
        chk("break_bp_hit", 64'(bp_hit), 64'h1);
        chk("break_count", 64'(instr_count), 64'h3);
        chk("break_halted", 64'(halted), 64'h1);
        c = cyc; step_btn = 1'b1; k = c + 1;
        push(k + 7, 32'hC, 2'b01);
        for (int i = 0; i < 6; i++) push(k + 9 + i, 32'h10 + 32'(4 * i), 2'b10);
        tick(7);
        chk("break_hold", 64'(state), 64'h3);
        tick(1);
        chk("step_clears_bp_hit", 64'(bp_hit), 64'h0);
        tick(5);
        run_sw = 1'b0;
        tick(3);
        chk("resume_halt", 64'(state), 64'h0);
        chk("resume_count", 64'(instr_count), 64'hA);
        step_btn = 1'b0;
        tick(8);

        // ---- BREAK: step request coincident with run switch falling ----
        do_reset();
        bp_addr = 32'hC; bp_valid = 1'b1;
        c = cyc; run_sw = 1'b1; k = c + 1;
        push(k + 2, 32'h0, 2'b10); push(k + 3, 32'h4, 2'b10); push(k + 4, 32'h8, 2'b10);
        tick(7);
        chk("sim_break", 64'(state), 64'h3);
        step_btn = 1'b1;
        tick(5);
        run_sw = 1'b0;
        tick(3);
        chk("sim_halt", 64'(state), 64'h0);
        chk("sim_count", 64'(instr_count), 64'h3);
        tick(5);
        chk("sim_still_halt", 64'(state), 64'h0);
        chk("sim_count_late", 64'(instr_count), 64'h3);
        step_btn = 1'b0;
        tick(8);
`else
        // ---- Breakpoint logic absent: armed breakpoint must not stop ----
        do_reset();
        bp_addr = 32'hC; bp_valid = 1'b1;
        c = cyc; run_sw = 1'b1; k = c + 1;
        for (int i = 0; i < 8; i++) push(k + 2 + i, 32'(4 * i), 2'b10);
        tick(6);
        chk("nobp_pc", 64'(pc), 64'hC);
        chk("nobp_cpu_en", 64'(cpu_en), 64'h1);
        chk("nobp_bp_hit", 64'(bp_hit), 64'h0);
        tick(2);
        run_sw = 1'b0;
        tick(3);
        chk("nobp_halt", 64'(state), 64'h0);
        chk("nobp_count", 64'(instr_count), 64'h8);
        chk("nobp_bp_hit_end", 64'(bp_hit), 64'h0);
`endif

        // ---- Counter wrap after 65536 committed instructions ----
        do_reset();
        c = cyc; run_sw = 1'b1; k = c + 1;
        for (int i = 0; i < 65536; i++) push(k + 2 + i, 32'(4 * i), 2'b10);
        tick(65536);
        run_sw = 1'b0;
        tick(2);
        chk("wrap_max", 64'(instr_count), 64'hFFFF);
        tick(2);
        chk("wrap_zero", 64'(instr_count), 64'h0);
        chk("wrap_halt", 64'(state), 64'h0);

        tick(5);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_run_ctrl.md
# riscv_run_ctrl

Execution controller for the single-cycle RISC-V core in `riscv_top`. It generates the core's clock enable (`cpu_en`) so a board user can single-step from a push button, free-run from a switch, or stop at a PC breakpoint. It also keeps an executed-instruction counter for the LED/SSD debug mux. It sits between the board I/O and the core, clocked by the core clock `rclk`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: number of consecutive cycles the synchronized button must differ from its debounced value before the debounced value flips; legal range ≥ 2.
- `CNT_W`, default 16: width of the instruction counter.

Ports:
- `rclk`  in  1  — single clock.
- `rst`  in  1  — reset; asynchronous and active-high.
- `step_btn`  in  1  — raw, asynchronous push button.
- `run_sw`  in  1  — raw, asynchronous run switch; level-sensitive.
- `pc`  in  32  — current PC of the core.
- `bp_addr`  in  32  — breakpoint address.
- `bp_valid`  in  1  — breakpoint armed.
- `cpu_en`  out  1  — core clock enable; the core commits one instruction per cycle in which this is high.
- `halted`  out  1  — high in HALT or BREAK.
- `bp_hit`  out  1  — sticky flag: the core stopped at a breakpoint.
- `state`  out  2  — FSM state: HALT=00, STEP=01, RUN=10, BREAK=11.
- `instr_count`  out  CNT_W  — number of cycles with `cpu_en` high.

## Operation
- **Synchronizers.** `step_btn` and `run_sw` each pass through a 2-flop synchronizer, producing `step_s` and `run_s`.
- **Debounce.**
  - Counter clears whenever `step_s` equals the debounced value.
  - Otherwise it increments.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge, the debounced value flips and the counter clears.
  - `step_req` is a 1-cycle registered pulse on the debounced 0→1 edge. A release (1→0 edge) produces nothing.
- **FSM.**
  - HALT:
    - `run_s`=1 → RUN. This has priority over a simultaneous `step_req`, which is dropped.
    - Otherwise `step_req` → STEP.
  - STEP: lasts exactly one cycle, then → HALT. The breakpoint is ignored in STEP.
  - RUN:
    - `run_s`=0 → HALT.
    - Otherwise `bp_match` → BREAK.
  - BREAK:
    - `run_s`=0 → HALT. This has priority; a simultaneous `step_req` is dropped.
    - Otherwise `step_req` → STEP.
  - Resuming after a breakpoint: step from BREAK → STEP → HALT → RUN (because `run_s` is still 1). The breakpoint instruction executes once, and the PC moves past it.
- **Breakpoint match.** `bp_match` = `bp_valid` & (`pc` == `bp_addr`), combinational.
- **Clock enable.** `cpu_en` = (state==STEP) | (state==RUN & ~`bp_match`). This is combinational, so the instruction at `bp_addr` is never executed on entry to BREAK.
- **bp_hit.** Set on the RUN→BREAK transition. Cleared on entry to STEP or RUN. Holds otherwise.
- **Instruction counter.** `instr_count` increments on every edge where `cpu_en`=1. It wraps from 2^CNT_W−1 to 0 with no flag.
- **halted.** `halted` = (state==HALT) | (state==BREAK).

## Timing
- **Reset values**, applied asynchronously by `rst`:
  - state=HALT.
  - `cpu_en`=0, `halted`=1, `bp_hit`=0, `instr_count`=0.
  - Synchronizer flops, debounce counter, debounced value and `step_req` all 0.
- **Reset mid-run.** `cpu_en` falls within the same cycle, with no clock needed. A step pending in the synchronizer or debounce pipeline is discarded; the button must be released and pressed again.
- **Step latency.** Button first sampled high at edge k (held stable): debounced value flips at edge k+1+D, `step_req` is high after edge k+2+D, and `cpu_en` is high for exactly the one cycle after edge k+3+D. D = DEBOUNCE_CYCLES.
- **Bounce.** A glitch shorter than D cycles at the synchronizer output produces no step.
- **Holding the button.** Holding it pressed indefinitely yields exactly one step.
- **Run latency.** `run_sw` sampled high at edge k → RUN at edge k+2 → `cpu_en` high from the cycle after edge k+2.
- **Run switch-off.** `run_sw` low at edge k → HALT at edge k+2. `cpu_en` stays high through edge k+2, except where `bp_match` blocks it.
- **Breakpoint in RUN.** `bp_match` drops `cpu_en` in the same cycle. BREAK and `bp_hit`=1 follow at the next edge.

## Configuration
- `RUN_CTRL_BP_EN` defined: breakpoint logic is present as described above.
- Undefined:
  - `bp_match` is tied to 0, and `pc`, `bp_addr` and `bp_valid` are ignored.
  - BREAK is unreachable.
  - `bp_hit` is constant 0.
  - `cpu_en` = (state==STEP) | (state==RUN).

## Test plan
Directed scenarios (DEBOUNCE_CYCLES=4, CNT_W=16, `RUN_CTRL_BP_EN` defined unless stated):
- **Reset:** assert `rst` between edges → immediately `cpu_en`=0, `halted`=1, `state`=00, `instr_count`=0.
- **Single step:** press `step_btn` at edge 10 and hold 20 cycles → `cpu_en` high only in the cycle after edge 17; `instr_count`=1; `state` goes 01 → 00. A 3-cycle bounce on press gives no extra step.
- **Run / breakpoint:** `bp_addr`=0x0000000C, `bp_valid`=1, `run_sw`=1, PC advancing 0,4,8,C → `cpu_en` low while `pc`=0xC; `state`=11, `bp_hit`=1, `instr_count`=3. A step then executes 0xC once, `bp_hit`=0, and RUN resumes at 0x10.
- **Simultaneous events:** in BREAK, `step_req` coincident with `run_s` falling → HALT, no `cpu_en` pulse, `instr_count` unchanged.
- **Wrap:** preload by running 65536 cycles → `instr_count` wraps to 0.
- **Macro off:** same stimulus as the run/breakpoint scenario without `RUN_CTRL_BP_EN` → no stop at 0xC, `bp_hit` stays 0.
